// File: rtl/i2s_tx_serializer.sv
// -----------------------------------------------------------------------------
// i2s_tx_serializer
//
// Output stage of the 96 kHz resampled audio path. It takes parallel L/R sample
// pairs from the interpolator, one pair per one-cycle din_valid strobe. It
// serializes them into a Philips-format I2S stream (BCLK, LRCK, SDATA) for the
// DAC. All I2S timing comes from the master clock clk.
//
// Frame geometry
//   frame_cnt runs 0 .. 2*WORD_BITS*BCLK_DIV-1. It is held here as a
//   (slot, phase) pair, so BCLK_DIV does not need to be a power of two:
//     slot  k = frame_cnt / BCLK_DIV
//     phase p = frame_cnt % BCLK_DIV
//   The shift register sr holds {L,R}.
//     - It is loaded at the last cycle of slot 0.
//     - It shifts left once at the last cycle of every other slot.
//   Because of this, the L MSB appears in slot 1. That is the one-bit I2S
//   delay after the LRCK edge.
//
// Sample buffering
//   A one-deep pending buffer decouples the upstream strobe from the frame
//   boundary. At the load point the source is chosen in this order:
//     1. the pending word;
//     2. a strobe arriving in that same cycle (bypass);
//     3. the last transmitted pair repeated (underrun).
//   If a pending word is overwritten before it is loaded, overrun is flagged.
//
// Output timing
//   All outputs are registered. While the counter shows n, the outputs show
//   the values belonging to n. The underrun/overrun flags are decided in
//   cycle n and appear as a one-cycle pulse in cycle n+1.
//
// Run control
//   run=0 synchronously returns everything to zero and overrides every other
//   action. The first cycle with run=1 arms the transmitter. The next cycle is
//   frame_cnt=0, with frame_start asserted.
//
// Ports
//   clk          in   master clock (49.152 MHz), rising edge
//   reset        in   asynchronous active-high reset
//   run          in   transmitter enable
//   din_valid    in   one-cycle strobe qualifying l_data_in / r_data_in
//   l_data_in    in   left sample, two's complement, MSB first on the wire
//   r_data_in    in   right sample
//   i2s_bclk     out  bit clock, BCLK_DIV clk per period, 50% duty
//   i2s_lrck     out  word select, 0 = left, 1 = right
//   i2s_sdata    out  serial data, changes on BCLK falling edge
//   frame_start  out  high while frame_cnt == 0 and running
//   underrun     out  pulse: a frame was loaded with no new sample
//   overrun      out  pulse: a pending sample was overwritten
// -----------------------------------------------------------------------------
module i2s_tx_serializer #(
    parameter int BCLK_DIV  = 8,
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 din_valid,
    input  logic [WORD_BITS-1:0] l_data_in,
    input  logic [WORD_BITS-1:0] r_data_in,
    output logic                 i2s_bclk,
    output logic                 i2s_lrck,
    output logic                 i2s_sdata,
    output logic                 frame_start,
    output logic                 underrun,
    output logic                 overrun
);

    localparam int SR_BITS = 2 * WORD_BITS;
    localparam int PHASE_W = $clog2(BCLK_DIV);
    localparam int SLOT_W  = $clog2(SR_BITS);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BCLK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(BCLK_DIV / 2);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SR_BITS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_RIGHT = SLOT_W'(WORD_BITS);
    localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);

    // ST_IDLE: held by run=0 / reset; ST_RUN: frame counter advancing.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                 state_reg,       state_next;
    logic [PHASE_W-1:0]     phase_reg,       phase_next;
    logic [SLOT_W-1:0]      slot_reg,        slot_next;
    logic [SR_BITS-1:0]     sr_reg,          sr_next;
    logic                   pend_full_reg,   pend_full_next;
    logic [WORD_BITS-1:0]   pend_l_reg,      pend_l_next;
    logic [WORD_BITS-1:0]   pend_r_reg,      pend_r_next;
    logic [WORD_BITS-1:0]   hold_l_reg,      hold_l_next;
    logic [WORD_BITS-1:0]   hold_r_reg,      hold_r_next;

    // ------------------------------------------------------ output registers
    logic                   bclk_reg,        bclk_next;
    logic                   lrck_reg,        lrck_next;
    logic                   sdata_reg,       sdata_next;
    logic                   frame_start_reg, frame_start_next;
    logic                   underrun_reg,    underrun_next;
    logic                   overrun_reg,     overrun_next;

    // ------------------------------------------------------- decode helpers
    logic                   running;
    logic                   end_of_slot;
    logic                   load_cycle;

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            phase_reg       <= '0;
            slot_reg        <= '0;
            sr_reg          <= '0;
            pend_full_reg   <= 1'b0;
            pend_l_reg      <= '0;
            pend_r_reg      <= '0;
            hold_l_reg      <= '0;
            hold_r_reg      <= '0;
            bclk_reg        <= 1'b0;
            lrck_reg        <= 1'b0;
            sdata_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            slot_reg        <= slot_next;
            sr_reg          <= sr_next;
            pend_full_reg   <= pend_full_next;
            pend_l_reg      <= pend_l_next;
            pend_r_reg      <= pend_r_next;
            hold_l_reg      <= hold_l_next;
            hold_r_reg      <= hold_r_next;
            bclk_reg        <= bclk_next;
            lrck_reg        <= lrck_next;
            sdata_reg       <= sdata_next;
            frame_start_reg <= frame_start_next;
            underrun_reg    <= underrun_next;
            overrun_reg     <= overrun_next;
        end
    end

    // ------------------------------------------- next-state and output logic
    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        slot_next        = slot_reg;
        sr_next          = sr_reg;
        pend_full_next   = pend_full_reg;
        pend_l_next      = pend_l_reg;
        pend_r_next      = pend_r_reg;
        hold_l_next      = hold_l_reg;
        hold_r_next      = hold_r_reg;
        underrun_next    = 1'b0;
        overrun_next     = 1'b0;

        running     = (state_reg == ST_RUN);
        end_of_slot = running && (phase_reg == PHASE_LAST);
        load_cycle  = end_of_slot && (slot_reg == '0);

        // Frame counter. The arming cycle leaves the counter at zero, so the
        // following cycle is a genuine frame_cnt == 0.
        if (running) begin
            if (phase_reg == PHASE_LAST) begin
                phase_next = '0;
                slot_next  = (slot_reg == SLOT_LAST) ? '0 : slot_reg + SLOT_ONE;
            end else begin
                phase_next = phase_reg + PHASE_ONE;
            end
        end else begin
            state_next = ST_RUN;
        end

        // Every slot except slot 0 ends with a shift. The shift at the end of
        // slot 63 leaves R[0] on the wire for slot 0 of the next frame.
        if (end_of_slot && !load_cycle) begin
            sr_next = {sr_reg[SR_BITS-2:0], 1'b0};
        end

        if (load_cycle) begin
            if (pend_full_reg) begin
                sr_next     = {pend_l_reg, pend_r_reg};
                hold_l_next = pend_l_reg;
                hold_r_next = pend_r_reg;
                if (din_valid) begin
                    // The old word drains while the new one takes its place.
                    // This is not an overwrite, so there is no overrun.
                    pend_l_next = l_data_in;
                    pend_r_next = r_data_in;
                end else begin
                    pend_full_next = 1'b0;
                end
            end else if (din_valid) begin
                sr_next     = {l_data_in, r_data_in};
                hold_l_next = l_data_in;
                hold_r_next = r_data_in;
            end else begin
                // Repeat the last pair. This is all zeros before the first
                // sample.
                sr_next       = {hold_l_reg, hold_r_reg};
                underrun_next = 1'b1;
            end
        end else if (din_valid) begin
            overrun_next   = pend_full_reg;
            pend_l_next    = l_data_in;
            pend_r_next    = r_data_in;
            pend_full_next = 1'b1;
        end

        // run=0 wins over everything, including a strobe in the same cycle.
        if (!run) begin
            state_next     = ST_IDLE;
            phase_next     = '0;
            slot_next      = '0;
            sr_next        = '0;
            pend_full_next = 1'b0;
            pend_l_next    = '0;
            pend_r_next    = '0;
            hold_l_next    = '0;
            hold_r_next    = '0;
            underrun_next  = 1'b0;
            overrun_next   = 1'b0;
        end

        // The line outputs are decoded from the next counter and next shift
        // register. Registering them this way keeps them aligned with
        // frame_cnt. While idle, every term below evaluates to zero.
        bclk_next        = (phase_next >= PHASE_HALF);
        lrck_next        = (slot_next >= SLOT_RIGHT);
        sdata_next       = sr_next[SR_BITS-1];
        frame_start_next = (state_next == ST_RUN) && (phase_next == '0)
                           && (slot_next == '0);
    end

    assign i2s_bclk    = bclk_reg;
    assign i2s_lrck    = lrck_reg;
    assign i2s_sdata   = sdata_reg;
    assign frame_start = frame_start_reg;
    assign underrun    = underrun_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for i2s_tx_serializer.
//
// The reference model works on whole sample words. It tracks:
//   - the frame position n;
//   - the pair currently on the wire;
//   - the pending and hold words.
// From these it derives what each output must be:
//   - slot k carries word[2*WB-k];
//   - slot 0 carries word[0] of the pair already on the wire.
//
// A separate deserializer samples SDATA on BCLK rising edges and rebuilds the
// received L/R pairs from the LRCK transitions.
// -----------------------------------------------------------------------------
module tb_i2s_tx_serializer;

    localparam int BD = 8;
    localparam int WB = 32;
    localparam int FL = 2 * WB * BD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic din_valid = 1'b0;
    logic [WB-1:0] l_data = '0;
    logic [WB-1:0] r_data = '0;
    logic i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, overrun;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.BCLK_DIV(BD), .WORD_BITS(WB)) dut (
        .clk         (clk),
        .reset       (rst),
        .run         (run),
        .din_valid   (din_valid),
        .l_data_in   (l_data),
        .r_data_in   (r_data),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    // ------------------------------------------------------------ model
    bit          m_active;
    int          m_n;
    logic [63:0] m_tx;
    logic [63:0] m_pend;
    logic [63:0] m_hold;
    bit          m_pend_full;
    bit          m_u;
    bit          m_o;
    int          u_cnt = 0;

    task automatic m_clear();
        m_active = 0; m_n = 0; m_tx = '0; m_pend = '0; m_hold = '0;
        m_pend_full = 0; m_u = 0; m_o = 0;
    endtask

    initial begin
        int k, p;
        bit e_bclk, e_lrck, e_sdata, e_fs, nu, no;
        m_clear();
        forever begin
            @(negedge clk);
            k = m_n / BD;
            p = m_n % BD;
            e_bclk  = m_active && (p >= BD / 2);
            e_lrck  = m_active && (k >= WB);
            e_sdata = m_active && ((k == 0) ? m_tx[0] : m_tx[2 * WB - k]);
            e_fs    = m_active && (m_n == 0);
            chk1($sformatf("bclk n=%0d", m_n), i2s_bclk, e_bclk);
            chk1($sformatf("lrck n=%0d", m_n), i2s_lrck, e_lrck);
            chk1($sformatf("sdata n=%0d", m_n), i2s_sdata, e_sdata);
            chk1($sformatf("frame_start n=%0d", m_n), frame_start, e_fs);
            chk1($sformatf("underrun n=%0d", m_n), underrun, m_u);
            chk1($sformatf("overrun n=%0d", m_n), overrun, m_o);
            if (underrun) u_cnt++;

            // advance the model with this cycle's inputs
            if (rst || !run) begin
                m_clear();
            end else begin
                nu = 0; no = 0;
                if (m_active && m_n == BD - 1) begin
                    if (m_pend_full) begin
                        m_tx = m_pend; m_hold = m_pend;
                        if (din_valid) m_pend = {l_data, r_data};
                        else m_pend_full = 0;
                    end else if (din_valid) begin
                        m_tx = {l_data, r_data}; m_hold = m_tx;
                    end else begin
                        m_tx = m_hold; nu = 1;
                    end
                end else if (din_valid) begin
                    no = m_pend_full;
                    m_pend = {l_data, r_data};
                    m_pend_full = 1;
                end
                m_u = nu; m_o = no;
                if (m_active) m_n = (m_n + 1) % FL;
                else begin m_active = 1; m_n = 0; end
            end
        end
    end

    // ------------------------------------------------------ deserializer
    logic [31:0] rx_sh = '0;
    logic [31:0] rx_l  = '0;
    logic        rx_prev = 1'b0;
    logic [63:0] rx_q[$];

    initial begin
        logic [31:0] s;
        forever begin
            @(posedge i2s_bclk);
            s = {rx_sh[30:0], i2s_sdata};
            rx_sh = s;
            if (i2s_lrck != rx_prev) begin
                if (i2s_lrck) rx_l = s;        // L LSB just arrived
                else rx_q.push_back({rx_l, s}); // R LSB just arrived
            end
            rx_prev = i2s_lrck;
        end
    end

    function automatic logic [63:0] rx_last();
        return (rx_q.size() > 0) ? rx_q[$] : 64'd0;
    endfunction

    // ------------------------------------------------------ stimulus helpers
    task automatic goto_n(input int target);
        int guard;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!(m_active && m_n == target) && guard < 2 * FL + 40);
        if (!(m_active && m_n == target)) begin
            n_checks++;
            $display("FAIL goto: frame_cnt %0d not reached in %0d cycles (at %0d)",
                     target, guard, m_n);
        end
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        din_valid = 1'b1; l_data = l; r_data = r;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        int u0, rxn0, rxn1, hits;
        run = 1'b1;
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk1("reset bclk", i2s_bclk, 1'b0);
        chk1("reset lrck", i2s_lrck, 1'b0);
        chk1("reset sdata", i2s_sdata, 1'b0);
        chk1("reset frame_start", frame_start, 1'b0);
        chk1("reset underrun", underrun, 1'b0);
        chk1("reset overrun", overrun, 1'b0);
        rst = 1'b0;

        // F0: basic timing, empty first frame
        goto_n(0);   chk1("F0 frame_start@0", frame_start, 1'b1);
        goto_n(4);   chk1("F0 bclk@4", i2s_bclk, 1'b1);
        goto_n(8);   chk1("F0 underrun@8", underrun, 1'b1);
        goto_n(256); chk1("F0 lrck@256", i2s_lrck, 1'b1);

        // Sample A in F1 at n=100, transmitted in F2
        goto_n(100); send_pair(32'h80000001, 32'h7FFFFFFE);
        goto_n(8);   chk1("A underrun@8", underrun, 1'b0);
        goto_n(12);  chk1("A slot1 L MSB", i2s_sdata, 1'b1);
        goto_n(20);  chk1("A slot2", i2s_sdata, 1'b0);
        goto_n(260); chk1("A slot32 L LSB", i2s_sdata, 1'b1);
        goto_n(268); chk1("A slot33 R MSB", i2s_sdata, 1'b0);
        goto_n(508); chk1("A slot63", i2s_sdata, 1'b1);
        goto_n(4);   chk1("A next slot0 R0", i2s_sdata, 1'b0);
        goto_n(6);   chk64("rx pair A", rx_last(), 64'h80000001_7FFFFFFE);

        // Sample B once, then two starving frames repeat it
        goto_n(100); send_pair(32'h00001234, 32'h00005678);
        goto_n(100); u0 = u_cnt; rxn0 = rx_q.size();
        goto_n(8);   chk1("B repeat underrun@8", underrun, 1'b1);
        goto_n(6);
        goto_n(6);
        chk64("B underrun count", 64'(u_cnt - u0), 64'd2);
        chk64("B rx count", 64'(rx_q.size() - rxn0), 64'd3);
        for (int i = rxn0; i < rx_q.size(); i++)
            chk64($sformatf("rx pair B[%0d]", i - rxn0), rx_q[i], 64'h00001234_00005678);

        // C then D in one frame: D overwrites C
        goto_n(100); send_pair(32'h11111111, 32'h22222222);
        goto_n(200); send_pair(32'hAAAA5555, 32'h5555AAAA);
        chk1("overrun@201", overrun, 1'b1);
        rxn1 = rx_q.size();
        goto_n(8);   chk1("D underrun@8", underrun, 1'b0);
        goto_n(6);   chk64("rx pair D", rx_last(), 64'hAAAA5555_5555AAAA);
        hits = 0;
        for (int i = rxn1; i < rx_q.size(); i++)
            if (rx_q[i] == 64'h11111111_22222222) hits++;
        chk64("C never sent", 64'(hits), 64'd0);

        // E strobed exactly at the load cycle (bypass)
        goto_n(7);   send_pair(32'h0F0F0F0F, 32'hF0F0F0F0);
        chk1("E bypass underrun@8", underrun, 1'b0);
        goto_n(12);  chk1("E slot1", i2s_sdata, 1'b0);
        goto_n(44);  chk1("E slot5", i2s_sdata, 1'b1);
        goto_n(6);   chk64("rx pair E", rx_last(), 64'h0F0F0F0F_F0F0F0F0);

        // Drop run mid-frame
        goto_n(300); run = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk1("idle bclk", i2s_bclk, 1'b0);
        chk1("idle lrck", i2s_lrck, 1'b0);
        chk1("idle frame_start", frame_start, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        run = 1'b1;
        goto_n(0);   chk1("restart frame_start", frame_start, 1'b1);
        goto_n(8);   chk1("restart underrun@8", underrun, 1'b1);
        goto_n(12);  chk1("restart slot1 zero", i2s_sdata, 1'b0);
        repeat (20) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
